// File: rtl/demux_1x32to8x32_regbank.sv
// ---------------------------------------------------------------------------
// demux_1x32to8x32_regbank
//
// Write port of the register file. It demultiplexes one 32-bit write stream
// into eight 32-bit holding registers, whose q0..q7 outputs feed the 8:1 read
// mux inputs i0..i7.
//
// Write handshake: a write is accepted when wr_valid && wr_ready at a rising
// edge. Byte k of q[wr_sel] takes wr_data byte k where wr_be[k] is set.
// wr_ack pulses for the single cycle after each accepted write.
// A clr_req seen in IDLE starts an 8-cycle sweep. Each cycle of the sweep
// reloads one register with INIT_VALUE, in index order 0..7. Writes are
// refused while the sweep runs.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   wr_valid  write request present
//   wr_ready  bank can accept a write this cycle (combinational)
//   wr_sel    target register index 0..7
//   wr_data   write data
//   wr_be     byte enables, bit k gates wr_data[8k+7:8k]
//   wr_ack    one-cycle pulse the cycle after an accepted write
//   clr_req   request a clear sweep
//   busy      clear sweep in progress
//   q0..q7    registered bank contents
//
// Optional feature, macro REGBANK_REG0_ZERO_EN:
//   When defined, q0 is hard zero. Writes to index 0 are acked but discarded,
//   and the sweep still takes 8 cycles.
// ---------------------------------------------------------------------------
module demux_1x32to8x32_regbank #(
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic        wr_ack,
    input  logic        clr_req,
    output logic        busy,
    output logic [31:0] q0,
    output logic [31:0] q1,
    output logic [31:0] q2,
    output logic [31:0] q3,
    output logic [31:0] q4,
    output logic [31:0] q5,
    output logic [31:0] q6,
    output logic [31:0] q7
);

`ifdef REGBANK_REG0_ZERO_EN
    localparam bit REG0_ZERO = 1'b1;
`else
    localparam bit REG0_ZERO = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t      state;
    logic [2:0]  ptr;
    logic [31:0] bank [8];
    logic [31:0] be_mask;
    logic        accept;

    // Reload value for a given register. Index 0 is pinned to zero when the
    // zero-register feature is built in.
    function automatic logic [31:0] init_of(input logic [2:0] idx);
        return (REG0_ZERO && idx == 3'd0) ? 32'h0000_0000 : INIT_VALUE;
    endfunction

    // wr_ready never depends on wr_valid. clr_req takes priority over a
    // simultaneous write.
    assign wr_ready = (state == IDLE) && !clr_req;
    assign accept   = wr_valid && wr_ready;

    always_comb begin
        be_mask = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            be_mask[8*k +: 8] = {8{wr_be[k]}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            wr_ack <= 1'b0;
            busy   <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                bank[i[2:0]] <= init_of(i[2:0]);
            end
        end else begin
            wr_ack <= accept;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end else if (accept && !(REG0_ZERO && wr_sel == 3'd0)) begin
                        bank[wr_sel] <= (bank[wr_sel] & ~be_mask) | (wr_data & be_mask);
                    end
                end
                CLEAR: begin
                    bank[ptr] <= init_of(ptr);
                    ptr       <= ptr + 3'd1;    // wraps 7 -> 0 as the sweep ends
                    if (ptr == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q0 = bank[0];
    assign q1 = bank[1];
    assign q2 = bank[2];
    assign q3 = bank[3];
    assign q4 = bank[4];
    assign q5 = bank[5];
    assign q6 = bank[6];
    assign q7 = bank[7];

endmodule

// File: tb/tb_demux_1x32to8x32_regbank.sv
// ---------------------------------------------------------------------------
// tb_demux_1x32to8x32_regbank
//
// Self-checking bench for demux_1x32to8x32_regbank.
//
// The reference model keeps the bank as a plain array and tracks the clear
// sweep as a count of remaining cycles. A negedge process compares every DUT
// output against the model on every cycle. Directed scenarios also check
// hand-computed literal values, followed by a randomized traffic phase.
// Honours REGBANK_REG0_ZERO_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_demux_1x32to8x32_regbank;

    localparam logic [31:0] INIT = 32'h0000_0000;
`ifdef REGBANK_REG0_ZERO_EN
    localparam bit Z0 = 1'b1;
`else
    localparam bit Z0 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        wr_ack;
    logic        clr_req = 1'b0;
    logic        busy;
    logic [31:0] q [8];

    int checks = 0;
    int errors = 0;

    demux_1x32to8x32_regbank #(.INIT_VALUE(INIT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .wr_ack   (wr_ack),
        .clr_req  (clr_req),
        .busy     (busy),
        .q0       (q[0]),
        .q1       (q[1]),
        .q2       (q[2]),
        .q3       (q[3]),
        .q4       (q[4]),
        .q5       (q[5]),
        .q6       (q[6]),
        .q7       (q[7])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m [8];
    int          sweep_left = 0;
    logic        m_ack = 1'b0;

    function automatic logic [31:0] init_of(input int i);
        return (Z0 && i == 0) ? 32'h0 : INIT;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m[i] = init_of(i);
            sweep_left = 0;
            m_ack      = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (sweep_left > 0) begin
                m[8 - sweep_left] = init_of(8 - sweep_left);
                sweep_left--;
            end else if (clr_req) begin
                sweep_left = 8;
            end else if (wr_valid) begin
                m_ack = 1'b1;
                if (!(Z0 && wr_sel == 3'd0)) begin
                    for (int k = 0; k < 4; k++)
                        if (wr_be[k]) m[wr_sel][8*k +: 8] = wr_data[8*k +: 8];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) chk($sformatf("model_q%0d", i), q[i], m[i]);
        chk("model_ack",   {31'b0, wr_ack},   {31'b0, m_ack});
        chk("model_busy",  {31'b0, busy},     {31'b0, (sweep_left > 0)});
        chk("model_ready", {31'b0, wr_ready}, {31'b0, (sweep_left == 0) && !clr_req});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] s, input logic [31:0] d, input logic [3:0] be);
        logic acc;
        acc      = 1'b0;
        wr_valid = 1'b1;
        wr_sel   = s;
        wr_data  = d;
        wr_be    = be;
        for (int n = 0; n < 20; n++) begin
            #1;
            acc = wr_ready;
            cyc();
            if (acc) break;
        end
        if (!acc) chk("write_timeout", 32'd0, 32'd1);
        wr_valid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int acks;
        int bsy;

        // Reset
        repeat (3) cyc();
        for (int i = 0; i < 8; i++) chk($sformatf("reset_q%0d", i), q[i], 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ack", {31'b0, wr_ack}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'b0, wr_ready}, 32'd1);

        // Full write to q3
        do_write(3'd3, 32'hDEAD_BEEF, 4'hF);
        chk("q3_full_write", q[3], 32'hDEAD_BEEF);
        chk("ack_after_write", {31'b0, wr_ack}, 32'd1);
        for (int i = 0; i < 8; i++)
            if (i != 3) chk($sformatf("others_zero_q%0d", i), q[i], 32'h0);
        cyc();
        chk("ack_single_pulse", {31'b0, wr_ack}, 32'd0);

        // Partial write
        do_write(3'd5, 32'h1122_3344, 4'hF);
        do_write(3'd5, 32'hAABB_CCDD, 4'b0101);
        chk("q5_partial", q[5], 32'h11BB_33DD);

        // Zero byte enables: acked, no change
        do_write(3'd5, 32'hFFFF_FFFF, 4'b0000);
        chk("be0_ack", {31'b0, wr_ack}, 32'd1);
        chk("be0_hold", q[5], 32'h11BB_33DD);

        // Eight back-to-back writes
        acks = 0;
        for (int s = 0; s < 8; s++) begin
            wr_valid = 1'b1;
            wr_sel   = 3'(s);
            wr_data  = 32'h100 + 32'(s);
            wr_be    = 4'hF;
            cyc();
            if (wr_ack) acks++;
        end
        wr_valid = 1'b0;
        chk("b2b_ack_count", 32'(acks), 32'd8);
        for (int n = 0; n < 8; n++)
            chk($sformatf("b2b_q%0d", n), q[n], (Z0 && n == 0) ? 32'h0 : 32'h100 + 32'(n));

        // Clear with a simultaneous write that must be held
        wr_valid = 1'b1;
        wr_sel   = 3'd2;
        wr_data  = 32'hCAFE_F00D;
        wr_be    = 4'hF;
        clr_req  = 1'b1;
        #1;
        chk("ready_low_on_clr", {31'b0, wr_ready}, 32'd0);
        cyc();
        clr_req = 1'b0;
        chk("busy_after_clr", {31'b0, busy}, 32'd1);
        chk("write_not_taken", {31'b0, wr_ack}, 32'd0);
        bsy = 0;
        for (int j = 0; j < 8; j++) begin
            if (busy) bsy++;
            cyc();
            chk($sformatf("sweep_cleared_q%0d", j), q[j], init_of(j));
            if (j < 7) chk($sformatf("sweep_pending_q%0d", j + 1), {31'b0, (q[j+1] != 32'h0)}, 32'd1);
        end
        chk("busy_cycles", 32'(bsy), 32'd8);
        chk("busy_dropped", {31'b0, busy}, 32'd0);
        cyc();
        wr_valid = 1'b0;
        chk("held_write_ack", {31'b0, wr_ack}, 32'd1);
        chk("held_write_q2", q[2], 32'hCAFE_F00D);

        // Randomized traffic
        repeat (300) begin
            wr_valid = 1'($urandom_range(0, 1));
            clr_req  = ($urandom_range(0, 24) == 0);
            wr_sel   = 3'($urandom_range(0, 7));
            wr_data  = $urandom;
            wr_be    = 4'($urandom_range(0, 15));
            cyc();
        end
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        repeat (10) cyc();

        // Reset in the middle of a sweep
        for (int s = 0; s < 8; s++) do_write(3'(s), 32'hA5A5_0000 | 32'(s + 1), 4'hF);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (3) cyc();
        chk("busy_mid_sweep", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) chk($sformatf("midreset_q%0d", i), q[i], init_of(i));
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_ack", {31'b0, wr_ack}, 32'd0);
        cyc();
        reset_n = 1'b1;
        #1;
        chk("ready_after_midreset", {31'b0, wr_ready}, 32'd1);

        // Register 0 behaviour
        do_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        chk("reg0_ack", {31'b0, wr_ack}, 32'd1);
        chk("reg0_value", q[0], Z0 ? 32'h0 : 32'hFFFF_FFFF);

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
